// File: rtl/frame_buffer_reader.sv
// Frame-buffer scan-out: maps screen counts to upscaled buffer addresses, expands RGB565
// read data to RGB888 and double-buffers with a frame-synchronous bank swap.
module frame_buffer_reader #(
   parameter int FB_WIDTH     = 320,
   parameter int FB_HEIGHT    = 180,
   parameter int SCALE_LOG2   = 2,
   parameter int BRAM_LATENCY = 2,
   parameter int ADDR_W       = 17
) (
   input  logic              pixel_clk,
   input  logic              rst,
   input  logic [10:0]       h_count_in,
   input  logic [9:0]        v_count_in,
   input  logic              h_sync_in,
   input  logic              v_sync_in,
   input  logic              active_draw_in,
   input  logic              new_frame_in,
   input  logic              swap_req,
   output logic [ADDR_W-1:0] rd_addr,
   output logic              rd_en,
   input  logic [15:0]       rd_data,
   output logic [7:0]        red,
   output logic [7:0]        green,
   output logic [7:0]        blue,
   output logic              h_sync_out,
   output logic              v_sync_out,
   output logic              active_draw_out,
   output logic              display_bank,
   output logic              swap_ack
);

   localparam int LAT = BRAM_LATENCY + 2;
   localparam logic [ADDR_W-1:0] BANK_SIZE = ADDR_W'(FB_WIDTH * FB_HEIGHT);
   localparam logic [ADDR_W-1:0] ROW_PITCH = ADDR_W'(FB_WIDTH);

   typedef enum logic {IDLE = 1'b0, PENDING = 1'b1} swap_state_t;

   function automatic logic [7:0] expand5(input logic [4:0] c);
      return {c, c[4:2]};
   endfunction

   function automatic logic [7:0] expand6(input logic [5:0] c);
      return {c, c[5:4]};
   endfunction

   swap_state_t       state_q, state_d;
   logic              bank_q, bank_d;
   logic              ack_q, ack_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic              en_q;
   logic [2:0]        dly_q [LAT];
   logic [23:0]       rgb_q, rgb_d;

   // Stage 1: buffer address; the bank register still holds its pre-toggle value here.
   always_comb begin
      addr_d = addr_q;
      if (active_draw_in) begin
         addr_d = (bank_q ? BANK_SIZE : '0)
                + ADDR_W'(v_count_in >> SCALE_LOG2) * ROW_PITCH
                + ADDR_W'(h_count_in >> SCALE_LOG2);
      end
   end

   // Output stage: colour is captured as the matching timing sample enters the last delay slot.
   always_comb begin
      rgb_d = '0;
      if (dly_q[LAT-2][0]) begin
         rgb_d = {expand5(rd_data[15:11]), expand6(rd_data[10:5]), expand5(rd_data[4:0])};
      end
   end

   always_comb begin
      state_d = state_q;
      bank_d  = bank_q;
      ack_d   = 1'b0;
      case (state_q)
         IDLE: begin
            if (swap_req && new_frame_in) begin
               bank_d = ~bank_q;
               ack_d  = 1'b1;
            end else if (swap_req) begin
               state_d = PENDING;
            end
         end
         PENDING: begin
            if (new_frame_in) begin
               bank_d  = ~bank_q;
               ack_d   = 1'b1;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge pixel_clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         bank_q  <= 1'b0;
         ack_q   <= 1'b0;
         addr_q  <= '0;
         en_q    <= 1'b0;
         rgb_q   <= '0;
         for (int i = 0; i < LAT; i++) dly_q[i] <= '0;
      end else begin
         state_q  <= state_d;
         bank_q   <= bank_d;
         ack_q    <= ack_d;
         addr_q   <= addr_d;
         en_q     <= active_draw_in;
         rgb_q    <= rgb_d;
         dly_q[0] <= {h_sync_in, v_sync_in, active_draw_in};
         for (int i = 1; i < LAT; i++) dly_q[i] <= dly_q[i-1];
      end
   end

   assign rd_addr         = addr_q;
   assign rd_en           = en_q;
   assign red             = rgb_q[23:16];
   assign green           = rgb_q[15:8];
   assign blue            = rgb_q[7:0];
   assign h_sync_out      = dly_q[LAT-1][2];
   assign v_sync_out      = dly_q[LAT-1][1];
   assign active_draw_out = dly_q[LAT-1][0];
   assign display_bank    = bank_q;
   assign swap_ack        = ack_q;

endmodule
